// File: rtl/riscv_lsu.sv
// Load/store unit: turns core data-memory requests into word-aligned, byte-enabled
// memory transactions, stalls the core until done, and aligns/extends load data.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [31:0] r_data;
  logic [7:0]  r_cnt;
  logic        r_misalign;
  logic        r_timeout;

  logic        w_misalign;
  logic        w_in_req;
  logic        w_in_resp;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Sizes 3, 6 and 7 have no defined access width and are rejected like misalignment.
  always_comb begin
    w_misalign = 1'b0;
    case (core_size_i)
      3'd0, 3'd4: w_misalign = 1'b0;
      3'd1, 3'd5: w_misalign = core_addr_i[0];
      3'd2:       w_misalign = (core_addr_i[1:0] != 2'b00);
      default:    w_misalign = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= '0;
      r_addr     <= '0;
      r_wd       <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (core_req_i) begin
            r_we       <= core_we_i;
            r_size     <= core_size_i;
            r_addr     <= core_addr_i;
            r_wd       <= core_wd_i;
            r_data     <= '0;
            r_cnt      <= '0;
            r_misalign <= w_misalign;
            r_timeout  <= 1'b0;
            r_state    <= w_misalign ? S_RESP : S_REQ;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 8'd1;
          if (mem_ready_i) begin
            r_data  <= mem_rd_i;
            r_state <= S_RESP;
          end else if (r_cnt == LP_TMO_LAST) begin
            r_data    <= '0;
            r_timeout <= 1'b1;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_byte = r_data[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = r_data[7:0];
      2'd1: w_byte = r_data[15:8];
      2'd2: w_byte = r_data[23:16];
      2'd3: w_byte = r_data[31:24];
      default: w_byte = r_data[7:0];
    endcase
    w_half = r_addr[1] ? r_data[31:16] : r_data[15:0];
    w_load = '0;
    case (r_size)
      3'd0: w_load = {{24{w_byte[7]}}, w_byte};
      3'd4: w_load = {24'd0, w_byte};
      3'd1: w_load = {{16{w_half[15]}}, w_half};
      3'd5: w_load = {16'd0, w_half};
      3'd2: w_load = r_data;
      default: w_load = '0;
    endcase
  end

  // Memory-side outputs decode only from registered state so an async reset clears them at once.
  always_comb begin
    w_in_req     = (r_state == S_REQ);
    w_in_resp    = (r_state == S_RESP);
    core_stall_o = core_req_i && (r_state != S_RESP);
    misalign_o   = w_in_resp && r_misalign;
    timeout_o    = w_in_resp && r_timeout;
    core_rd_o    = (w_in_resp && !r_we && !r_misalign && !r_timeout) ? w_load : '0;
    mem_req_o    = w_in_req;
    mem_we_o     = w_in_req && r_we;
    mem_addr_o   = w_in_req ? {r_addr[31:2], 2'b00} : '0;
    mem_be_o     = '0;
    mem_wd_o     = '0;
    if (w_in_req) begin
      case (r_size[1:0])
        2'd0: begin
          mem_be_o = 4'b0001 << r_addr[1:0];
          mem_wd_o = {4{r_wd[7:0]}};
        end
        2'd1: begin
          mem_be_o = 4'b0011 << r_addr[1:0];
          mem_wd_o = {2{r_wd[15:0]}};
        end
        default: begin
          mem_be_o = 4'b1111;
          mem_wd_o = r_wd;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: vector table with a response scoreboard,
// plus directed sequences for reset, back-to-back and dropped-request cases.
module tb_riscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        misalign_o;
  logic        timeout_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .misalign_o   (misalign_o),
    .timeout_o    (timeout_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mrd;
    int          waits;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;
    logic        mis;
    logic        tmo;
    int          reqs;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        tmo;
    int          reqs;
    int          stall;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   req_cnt;
    int   stall_hi;
    bit   done;
    @(negedge clk_i);
    core_req_i  = 1'b1;
    core_we_i   = v.we;
    core_size_i = v.size;
    core_addr_i = v.addr;
    core_wd_i   = v.wd;
    mem_rd_i    = v.mrd;
    mem_ready_i = 1'b0;
    e.rd = v.rd; e.mis = v.mis; e.tmo = v.tmo; e.reqs = v.reqs; e.stall = v.reqs + 1;
    sb.push_back(e);
    #1;
    chk("idle_stall", {31'd0, core_stall_o}, 32'd1);
    chk("idle_pulses", {30'd0, misalign_o, timeout_o}, 32'd0);
    req_cnt  = 0;
    stall_hi = 1;
    done     = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk_i);
      if (mem_req_o) begin
        req_cnt++;
        chk("mem_addr", mem_addr_o, {v.addr[31:2], 2'b00});
        chk("mem_be", {28'd0, mem_be_o}, {28'd0, v.be});
        chk("mem_we", {31'd0, mem_we_o}, {31'd0, v.we});
        chk("mem_wd", mem_wd_o, v.mwd);
        mem_ready_i = (req_cnt == v.waits + 1);
      end else begin
        mem_ready_i = 1'b0;
        chk("mem_idle_ctl", {27'd0, mem_we_o, mem_be_o}, 32'd0);
        chk("mem_idle_addr", mem_addr_o, 32'd0);
        chk("mem_idle_wd", mem_wd_o, 32'd0);
      end
      if (core_stall_o) begin
        stall_hi++;
        chk("rd_not_resp", core_rd_o, 32'd0);
        chk("pulse_not_resp", {30'd0, misalign_o, timeout_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_rd", core_rd_o, e.rd);
        chk("resp_misalign", {31'd0, misalign_o}, {31'd0, e.mis});
        chk("resp_timeout", {31'd0, timeout_o}, {31'd0, e.tmo});
        chk("req_cycles", req_cnt, e.reqs);
        chk("stall_cycles", stall_hi, e.stall);
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
        done        = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL resp_budget actual=no_resp expected=resp addr=%h", v.addr);
      if (sb.size() > 0) void'(sb.pop_front());
      core_req_i  = 1'b0;
      mem_ready_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          we    size  addr          wd            mem_rd        wt  be       mem_wd        rd            mis   tmo   reqs
    vecs[0]  = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0,  4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0, 1};
    vecs[1]  = '{1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h8011_2233, 0,  4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0, 1};
    vecs[2]  = '{1'b0, 3'd4, 32'h0000_0103, 32'h0,        32'h8011_2233, 0,  4'b1000, 32'h0,        32'h0000_0080, 1'b0, 1'b0, 1};
    vecs[3]  = '{1'b1, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 32'h0,        2,  4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0, 1'b0, 3};
    vecs[4]  = '{1'b0, 3'd2, 32'h0000_0101, 32'h0,        32'h1234_5678, 0,  4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 0};
    vecs[5]  = '{1'b0, 3'd2, 32'h0000_0300, 32'h0,        32'h1234_5678, 99, 4'b1111, 32'h0,        32'h0,        1'b0, 1'b1, 4};
    vecs[6]  = '{1'b0, 3'd1, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 0,  4'b1100, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0, 1};
    vecs[7]  = '{1'b0, 3'd5, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1,  4'b1100, 32'h0,        32'h0000_8001, 1'b0, 1'b0, 2};
    vecs[8]  = '{1'b0, 3'd1, 32'h0000_0100, 32'h0,        32'h8001_7FFF, 0,  4'b0011, 32'h0,        32'h0000_7FFF, 1'b0, 1'b0, 1};
    vecs[9]  = '{1'b0, 3'd0, 32'h0000_0101, 32'h0,        32'h1122_3344, 0,  4'b0010, 32'h0,        32'h0000_0033, 1'b0, 1'b0, 1};
    vecs[10] = '{1'b1, 3'd0, 32'h0000_0401, 32'hFFFF_FF5A, 32'hFFFF_FFFF, 1,  4'b0010, 32'h5A5A_5A5A, 32'h0,        1'b0, 1'b0, 2};
    vecs[11] = '{1'b1, 3'd2, 32'h0000_0500, 32'hCAFE_F00D, 32'h0,        0,  4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b0, 1};
    vecs[12] = '{1'b0, 3'd5, 32'h0000_0203, 32'h0,        32'hFFFF_FFFF, 0,  4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 0};
    vecs[13] = '{1'b0, 3'd3, 32'h0000_0200, 32'h0,        32'hFFFF_FFFF, 0,  4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 0};
    vecs[14] = '{1'b1, 3'd1, 32'h0000_0201, 32'h0000_1234, 32'h0,        0,  4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 0};

    rst_i       = 1'b0;
    core_req_i  = 1'b0;
    core_we_i   = 1'b0;
    core_size_i = 3'd0;
    core_addr_i = '0;
    core_wd_i   = '0;
    mem_rd_i    = '0;
    mem_ready_i = 1'b0;

    #13;
    chk("rst_rd", core_rd_o, 32'd0);
    chk("rst_ctl", {26'd0, core_stall_o, misalign_o, timeout_o, mem_req_o, mem_we_o, 1'b0}, 32'd0);
    chk("rst_mem", {28'd0, mem_be_o} | mem_addr_o | mem_wd_o, 32'd0);
    core_req_i = 1'b1;
    #1;
    chk("rst_stall_follows_req", {31'd0, core_stall_o}, 32'd1);
    core_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back with mem_ready_i held high, including in IDLE where it must be ignored.
    @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
    core_addr_i = 32'h600; mem_rd_i = 32'h0102_0304; mem_ready_i = 1'b1;
    @(negedge clk_i);
    chk("b2b_req1", {31'd0, mem_req_o}, 32'd1);
    @(negedge clk_i);
    chk("b2b_resp1", core_rd_o, 32'h0102_0304);
    core_addr_i = 32'h604; mem_rd_i = 32'h0A0B_0C0D;
    @(negedge clk_i);
    chk("b2b_idle_gap", {30'd0, mem_req_o, core_stall_o}, 32'd1);
    @(negedge clk_i);
    chk("b2b_req2_addr", mem_addr_o, 32'h604);
    @(negedge clk_i);
    chk("b2b_resp2", core_rd_o, 32'h0A0B_0C0D);
    chk("b2b_resp2_stall", {31'd0, core_stall_o}, 32'd0);
    core_req_i = 1'b0; mem_ready_i = 1'b0;

    // Request dropped while in REQ: transaction still completes.
    @(negedge clk_i);
    core_req_i = 1'b1; core_size_i = 3'd2; core_addr_i = 32'h700; mem_rd_i = 32'hA5A5_A5A5;
    @(negedge clk_i);
    chk("drop_req_cycle1", {31'd0, mem_req_o}, 32'd1);
    core_req_i = 1'b0;
    @(negedge clk_i);
    chk("drop_req_cycle2", {31'd0, mem_req_o}, 32'd1);
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    chk("drop_resp_rd", core_rd_o, 32'hA5A5_A5A5);
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    chk("drop_after_rd", core_rd_o, 32'd0);

    // Asynchronous reset in the middle of REQ.
    core_req_i = 1'b1; core_size_i = 3'd2; core_addr_i = 32'h800;
    @(negedge clk_i);
    chk("mid_rst_in_req", {31'd0, mem_req_o}, 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("mid_rst_req_drop", {31'd0, mem_req_o}, 32'd0);
    chk("mid_rst_mem", {28'd0, mem_be_o} | mem_addr_o, 32'd0);
    core_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_idle", {30'd0, mem_req_o, core_stall_o}, 32'd0);
    run_vec(vecs[0]);
    run_vec(vecs[5]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit placed between the single-cycle core's data-memory outputs and a data memory with variable latency.
- Converts each core memory request into a word-aligned, byte-enabled memory transaction and holds the core with a stall until the transaction finishes.
- Aligns and sign- or zero-extends load data.
- Detects misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of cycles spent in REQ waiting for mem_ready_i before the access is aborted (range 1..255).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- core_req_i  in  1  core requests a memory access (level, held while core_stall_o=1)
- core_we_i  in  1  1=store, 0=load
- core_size_i  in  3  riscv_pkg encoding: 0=B, 1=H, 2=W, 4=BU, 5=HU
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, right-aligned
- core_rd_o  out  32  aligned/extended load data, valid in RESP
- core_stall_o  out  1  core must hold PC/regfile writes
- misalign_o  out  1  one-cycle pulse: access rejected as misaligned
- timeout_o  out  1  one-cycle pulse: access aborted by timeout
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word address, bits [1:0]=0
- mem_wd_o  out  32  lane-replicated write data
- mem_rd_i  in  32  memory read word
- mem_ready_i  in  1  memory completes the current request this cycle

Behaviour:
- FSM states: IDLE, REQ, RESP.
- Reset (rst_i=0, any time, including mid-transaction):
  - state=IDLE, timeout counter=0, captured data=0.
  - All outputs 0 except core_stall_o, which follows its combinational rule.
- core_stall_o = core_req_i && state!=RESP (combinational).
- IDLE:
  - On core_req_i=1, latch we/size/addr/wd.
  - Aligned access: go to REQ.
  - Misaligned access (H/HU with addr[0]=1; W with addr[1:0]!=0; size 3, 6 or 7 also counts as misaligned): go to RESP and pulse misalign_o in that RESP cycle. No mem_req_o is issued.
- REQ:
  - mem_req_o=1, driven from the latched values. mem_addr_o = {addr[31:2],2'b00}.
  - Byte enables: B/BU = 1<<addr[1:0]; H/HU = 4'b0011<<addr[1:0]; W = 4'b1111.
  - mem_wd_o: byte replicated into 4 lanes, halfword into 2 lanes, word passed through.
  - Counter increments each REQ cycle.
  - On mem_ready_i=1: capture mem_rd_i, go to RESP.
  - Else, if counter reaches TIMEOUT_CYCLES-1 without ready: go to RESP, pulse timeout_o in RESP, captured data=0.
  - mem_ready_i outside REQ is ignored.
- RESP:
  - Exactly one cycle; core_stall_o=0 so the core retires the instruction. Counter cleared. Next state IDLE.
  - core_rd_o, loads only:
    - Select byte (addr[1:0]) or halfword (addr[1]) from the captured word.
    - B/H sign-extend; BU/HU zero-extend; W passes through.
  - core_rd_o=0 on stores, misaligned accesses and timeouts.
  - Outside RESP, core_rd_o=0.
- Latency: aligned access with ready in the first REQ cycle takes 3 cycles from first core_req_i to the unstall cycle (IDLE, REQ, RESP). Each extra wait cycle adds one.
- Back-to-back: after RESP, IDLE samples the next core_req_i, so there is one IDLE cycle per access.
- core_req_i dropping while in REQ does not abort the transaction; it completes and RESP still occurs.
- mem_req_o, mem_we_o, mem_be_o, mem_addr_o and mem_wd_o are all 0 outside REQ.

Test Plan:
- Word load, ready in the first REQ cycle:
  - Stimulus: addr=0x100, size=2, mem_rd_i=0xDEADBEEF.
  - Response: mem_addr_o=0x100, mem_be_o=4'b1111; stall high 2 cycles then low 1; core_rd_o=0xDEADBEEF in RESP.
- Byte loads:
  - size=0 at addr=0x103, mem_rd_i=0x80112233 → mem_be_o=4'b1000, core_rd_o=0xFFFFFF80.
  - size=4, same address and data → core_rd_o=0x00000080.
- Halfword store:
  - addr=0x202, wd=0x0000ABCD, 2 wait cycles.
  - Response: mem_be_o=4'b1100, mem_wd_o=0xABCDABCD, mem_we_o=1 for 3 REQ cycles; stall high 4 cycles total.
- Misaligned word load at addr=0x101:
  - mem_req_o never asserted; misalign_o=1 and core_rd_o=0 in the second cycle; stall low that cycle.
- Timeout:
  - TIMEOUT_CYCLES=4, mem_ready_i held 0.
  - Response: exactly 4 REQ cycles, then timeout_o pulse in RESP, core_rd_o=0, back to IDLE.
- Reset mid-REQ:
  - Drive rst_i=0 asynchronously while in REQ.
  - Response: mem_req_o drops immediately without a clock edge; after release, state=IDLE and a new request completes normally.
